// File: rtl/BitScan.sv
// Operation and state encodings for the multi-cycle bit-scan engine.
package BitScan;

   typedef enum logic [2:0] {
      MSB    = 3'd0,
      CLZ    = 3'd1,
      CLO    = 3'd2,
      POPCNT = 3'd3,
      CLOG2  = 3'd4
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/Function.sv
// Small elaboration-time helpers shared by parametrised blocks.
package Function;

   function automatic bit IsPowerOf2(input int unsigned value);
      return (value != 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/bit_scan_chunk.sv
// Combinational per-chunk analysis: leading zeros and set-bit count of one STEP-bit slice.
module bit_scan_chunk #(
   parameter int STEP = 8,
   localparam int LW = $clog2(STEP) + 1
) (
   input  logic [STEP-1:0] chunk,
   output logic            nonzero,
   output logic [LW-1:0]   lead_zeros,
   output logic [LW-1:0]   ones
);

   logic seen;

   assign nonzero = |chunk;

   // Scan from the top bit down; the first set bit fixes the leading-zero count.
   always_comb begin
      lead_zeros = LW'(STEP);
      seen       = 1'b0;
      ones       = '0;
      for (int i = STEP - 1; i >= 0; i--) begin
         if (!seen && chunk[i]) begin
            lead_zeros = LW'(STEP - 1 - i);
            seen       = 1'b1;
         end
         ones = ones + LW'(chunk[i]);
      end
   end

endmodule

// File: rtl/bit_scan_unit.sv
// Multi-cycle MSB/CLZ/CLO/POPCNT/CLOG2 engine scanning STEP bits per cycle, MSB-first.
module bit_scan_unit
   import BitScan::*;
   import Function::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 8,
   localparam int RW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RW-1:0]    out_result,
   output logic             out_zero,
   output logic             out_pow2,
   output logic             out_err
);

   localparam int N  = WIDTH / STEP;
   localparam int MW = $clog2(WIDTH);
   localparam int LW = $clog2(STEP) + 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || !IsPowerOf2(WIDTH)) begin : g_bad_width
      $fatal(1, "bit_scan_unit: WIDTH must be a power of two >= 2");
   end
   if (!IsPowerOf2(STEP) || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
      $fatal(1, "bit_scan_unit: STEP must be a power of two dividing WIDTH");
   end

   state_t           state;
   logic [WIDTH-1:0] operand;
   logic [2:0]       mode;
   logic [CW-1:0]    count;
   logic             found;
   logic [MW-1:0]    msb;
   logic [RW-1:0]    pop;

   logic [WIDTH-1:0] shifted;
   logic [STEP-1:0]  chunk;
   logic             nonzero;
   logic [LW-1:0]    leadZeros;
   logic [LW-1:0]    ones;

   logic             foundNext;
   logic [MW-1:0]    msbNext;
   logic [RW-1:0]    popNext;
   logic [RW-1:0]    resultNext;
   logic             zeroNext;
   logic             pow2Next;
   logic             errNext;

   // The current chunk is brought to the top of the word so one slice feeds the shared analyser.
   assign shifted = operand << (int'(count) * STEP);
   assign chunk   = shifted[WIDTH-1 -: STEP];

   bit_scan_chunk #(.STEP(STEP)) u_chunk (
      .chunk      (chunk),
      .nonzero    (nonzero),
      .lead_zeros (leadZeros),
      .ones       (ones)
   );

   // Accumulator values including this cycle's chunk, so the final result is ready on the last scan edge.
   always_comb begin
      foundNext = found | nonzero;
      msbNext   = msb;
      if (!found && nonzero) begin
         msbNext = MW'(WIDTH - 1 - int'(count) * STEP - int'(leadZeros));
      end
      popNext = pop + RW'(ones);
   end

   always_comb begin
      resultNext = '0;
      zeroNext   = !foundNext;
      pow2Next   = (popNext == RW'(1));
      errNext    = 1'b0;
      case (mode)
         MSB:      resultNext = foundNext ? RW'(msbNext) : '0;
         CLZ, CLO: resultNext = foundNext ? (RW'(WIDTH - 1) - RW'(msbNext)) : RW'(WIDTH);
         POPCNT:   resultNext = popNext;
         CLOG2:    resultNext = !foundNext ? '0 : (pow2Next ? RW'(msbNext) : RW'(msbNext) + RW'(1));
         default: begin
            errNext  = 1'b1;
            zeroNext = 1'b0;
            pow2Next = 1'b0;
         end
      endcase
   end

   // Control FSM; in_ready is held low through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
         out_pow2   <= 1'b0;
         out_err    <= 1'b0;
         operand    <= '0;
         mode       <= '0;
         count      <= '0;
         found      <= 1'b0;
         msb        <= '0;
         pop        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  operand  <= (in_mode == CLO) ? ~in_data : in_data;
                  mode     <= in_mode;
                  count    <= '0;
                  found    <= 1'b0;
                  msb      <= '0;
                  pop      <= '0;
                  in_ready <= 1'b0;
                  state    <= SCAN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            SCAN: begin
               found <= foundNext;
               msb   <= msbNext;
               pop   <= popNext;
               count <= count + CW'(1);
               if (count == CW'(N - 1)) begin
                  out_result <= resultNext;
                  out_zero   <= zeroNext;
                  out_pow2   <= pow2Next;
                  out_err    <= errNext;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_scan_unit.sv
// Directed self-checking bench for bit_scan_unit at WIDTH=32, STEP=8 (four scan cycles).
module tb_bit_scan_unit;
   import BitScan::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [2:0]  in_mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  out_result;
   logic        out_zero;
   logic        out_pow2;
   logic        out_err;

   int assertCount = 0;
   int failCount = 0;

   bit_scan_unit #(.WIDTH(32), .STEP(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_pow2   (out_pow2),
      .out_err    (out_err)
   );

   always #5 clk = ~clk;

   // Presents one request, lets it be accepted, then scrambles the inputs and counts edges to out_valid.
   task automatic runOp(input logic [31:0] data, input logic [2:0] mode, output int lat);
      int guard;
      lat = -1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = data;
      in_mode = mode;
      out_ready = 1'b0;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data = ~data;
      in_mode = 3'd7;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic finishOp();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      assertCount++;
      if ({in_ready, out_valid, out_zero, out_pow2, out_err} !== 5'b0) begin
         failCount++;
         $display("[TB] FAIL reset_flags: got %b want 00000", {in_ready, out_valid, out_zero, out_pow2, out_err});
      end
      assertCount++;
      if (out_result !== 6'd0) begin
         failCount++;
         $display("[TB] FAIL reset_result: got %0d want 0", out_result);
      end
      rst_n = 1'b1;
      #1;
      assertCount++;
      if (in_ready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_ready_before_edge: got %b want 0", in_ready);
      end
      @(posedge clk);
      #1;
      assertCount++;
      if (in_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_ready_after_edge: got %b want 1", in_ready);
      end
   endtask

   task automatic test_msb();
      int lat;
      runOp(32'h0001_0000, MSB, lat);
      assertCount++;
      if (lat !== 4) begin
         failCount++;
         $display("[TB] FAIL msb_latency: got %0d want 4", lat);
      end
      assertCount++;
      if (out_result !== 6'd16) begin
         failCount++;
         $display("[TB] FAIL msb_result: got %0d want 16", out_result);
      end
      assertCount++;
      if ({out_zero, out_pow2, out_err} !== 3'b010) begin
         failCount++;
         $display("[TB] FAIL msb_flags: got %b want 010", {out_zero, out_pow2, out_err});
      end
      finishOp();
      assertCount++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failCount++;
         $display("[TB] FAIL msb_handshake: got valid/ready %b want 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_clog2();
      logic [31:0] data [3] = '{32'h40, 32'h41, 32'h1};
      logic [5:0]  expR [3] = '{6'd6, 6'd7, 6'd0};
      logic        expP [3] = '{1'b1, 1'b0, 1'b1};
      int lat;
      for (int k = 0; k < 3; k++) begin
         runOp(data[k], CLOG2, lat);
         assertCount++;
         if (out_result !== expR[k] || lat !== 4) begin
            failCount++;
            $display("[TB] FAIL clog2_%0h: got result %0d lat %0d want %0d lat 4", data[k], out_result, lat, expR[k]);
         end
         assertCount++;
         if (out_pow2 !== expP[k]) begin
            failCount++;
            $display("[TB] FAIL clog2_pow2_%0h: got %b want %b", data[k], out_pow2, expP[k]);
         end
         finishOp();
      end
   endtask

   task automatic test_boundaries();
      logic [2:0]  mode [6] = '{CLZ, CLO, CLZ, POPCNT, CLO, MSB};
      logic [31:0] data [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF0F0_00FF, 32'hFF00_0000, 32'h0};
      logic [5:0]  expR [6] = '{6'd32, 6'd32, 6'd0, 6'd16, 6'd8, 6'd0};
      logic        expZ [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        expP [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      int lat;
      for (int k = 0; k < 6; k++) begin
         runOp(data[k], mode[k], lat);
         assertCount++;
         if (out_result !== expR[k]) begin
            failCount++;
            $display("[TB] FAIL boundary_result_%0d: got %0d want %0d", k, out_result, expR[k]);
         end
         assertCount++;
         if ({out_zero, out_pow2, out_err} !== {expZ[k], expP[k], 1'b0}) begin
            failCount++;
            $display("[TB] FAIL boundary_flags_%0d: got %b want %b", k, {out_zero, out_pow2, out_err}, {expZ[k], expP[k], 1'b0});
         end
         finishOp();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int stableBad;
      runOp(32'h0040_0000, MSB, lat);
      assertCount++;
      if (lat !== 4 || out_result !== 6'd22) begin
         failCount++;
         $display("[TB] FAIL bp_first: got result %0d lat %0d want 22 lat 4", out_result, lat);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'h8;
      in_mode = MSB;
      out_ready = 1'b0;
      stableBad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if ({out_valid, in_ready, out_zero, out_pow2, out_err} !== 5'b10010 || out_result !== 6'd22) stableBad++;
      end
      assertCount++;
      if (stableBad !== 0) begin
         failCount++;
         $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0", stableBad);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      assertCount++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failCount++;
         $display("[TB] FAIL bp_release: got valid/ready %b want 01", {out_valid, in_ready});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data = 32'hFFFF_FFFF;
      assertCount++;
      if (in_ready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bp_accept: got in_ready %b want 0", in_ready);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      assertCount++;
      if (lat !== 4 || out_result !== 6'd3) begin
         failCount++;
         $display("[TB] FAIL bp_held_request: got result %0d lat %0d want 3 lat 4", out_result, lat);
      end
      finishOp();
   endtask

   task automatic test_illegal();
      int lat;
      runOp(32'h1234, 3'd5, lat);
      assertCount++;
      if (lat !== 4) begin
         failCount++;
         $display("[TB] FAIL illegal_latency: got %0d want 4", lat);
      end
      assertCount++;
      if ({out_err, out_zero, out_pow2} !== 3'b100 || out_result !== 6'd0) begin
         failCount++;
         $display("[TB] FAIL illegal_outputs: got err/zero/pow2 %b result %0d want 100 result 0", {out_err, out_zero, out_pow2}, out_result);
      end
      finishOp();
   endtask

   task automatic test_back_to_back();
      int firstE = -1;
      int secondE = -1;
      logic [5:0] firstR = '0;
      logic [5:0] secondR = '0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'hFFFF_FFFF;
      in_mode = POPCNT;
      out_ready = 1'b1;
      for (int e = 0; e < 12; e++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            if (firstE < 0) begin
               firstE = e;
               firstR = out_result;
            end else if (secondE < 0) begin
               secondE = e;
               secondR = out_result;
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      assertCount++;
      if (firstE !== 4 || secondE !== 10) begin
         failCount++;
         $display("[TB] FAIL b2b_timing: got edges %0d,%0d want 4,10", firstE, secondE);
      end
      assertCount++;
      if (firstR !== 6'd32 || secondR !== 6'd32) begin
         failCount++;
         $display("[TB] FAIL b2b_popcnt: got %0d,%0d want 32,32", firstR, secondR);
      end
   endtask

   task automatic test_reset_mid_scan();
      int guard;
      int lat;
      bit sawValid;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 32'h00FF;
      in_mode = MSB;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      assertCount++;
      if ({out_valid, in_ready} !== 2'b00) begin
         failCount++;
         $display("[TB] FAIL midscan_reset: got valid/ready %b want 00", {out_valid, in_ready});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      assertCount++;
      if (in_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL midscan_ready: got %b want 1", in_ready);
      end
      sawValid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid !== 1'b0) sawValid = 1'b1;
      end
      assertCount++;
      if (sawValid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL midscan_abandon: got out_valid %b want 0", sawValid);
      end
      runOp(32'h3, MSB, lat);
      assertCount++;
      if (out_result !== 6'd1 || lat !== 4) begin
         failCount++;
         $display("[TB] FAIL midscan_after: got result %0d lat %0d want 1 lat 4", out_result, lat);
      end
      finishOp();
   endtask

   initial begin
      test_reset();
      test_msb();
      test_clog2();
      test_boundaries();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
